nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-word adder that computes a WIDTH-bit sum by sequencing operands one nibble per cycle
//   through a 4-bit carry-lookahead slice, registering the carry between nibbles.
//   Sits upstream of the 4-bit CLA datapath and feeds it; downstream logic sees a valid/ready result.
//   Trades latency for area when wide adds are needed.
// PARAMETERS
//   WIDTH    16   operand/sum width in bits; must be a multiple of 4, minimum 4
//   NIBBLES  WIDTH/4   localparam: number of slice cycles per operation
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a/b/cin are valid
//   in_ready   out  1      block can accept an operation
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to nibble 0
//   out_valid  out  1      sum/cout are valid
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout       out  1      carry-out of the top nibble
//   ovf        out  1      signed overflow; present only with OVERFLOW_FLAG_EN
// BEHAVIOUR
//   Reset: one clock, asynchronous, active-low. While rst_n=0:
//     - state=IDLE; idx, carry, sum, cout, ovf all cleared to 0
//     - out_valid=0; in_ready=1 once rst_n deasserts
//   FSM states: IDLE -> RUN -> DONE -> IDLE
//     - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b into operand regs, carry<=cin, idx<=0; go to RUN.
//     - RUN: in_ready=0. Each cycle, the slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry.
//         Write the result into sum[4*idx+:4]; carry<=slice cout; idx<=idx+1.
//         After slice idx==NIBBLES-1: cout<=slice cout; go to DONE.
//     - DONE: out_valid=1; sum/cout held stable. in_ready=0.
//         On out_ready=1, out_valid drops next edge and the FSM returns to IDLE.
//   Latency: accept edge T -> out_valid high after edge T+NIBBLES. WIDTH=16 gives 4 cycles; WIDTH=4 gives 1 cycle.
//   Throughput: one op per NIBBLES+2 cycles max. No same-cycle re-accept in DONE.
//   Operand inputs changing after the accept edge have no effect. in_valid while busy is ignored, not queued.
//   out_ready while not in DONE is ignored.
//   sum is visible mid-RUN (partially filled) but is only defined while out_valid=1.
//   Reset mid-RUN or mid-DONE aborts the operation immediately. The result is discarded and out_valid=0.
//   idx width = $clog2(NIBBLES), minimum 1; idx never exceeds NIBBLES-1.
// CONFIGURATION
//   OVERFLOW_FLAG_EN defined:
//     - ovf port exists.
//     - At the final RUN cycle, ovf <= carry-into-MSB XOR carry-out-of-MSB.
//     - The slice exports its bit-3 carry-in for this.
//     - ovf is held with sum, cleared on reset.
//   OVERFLOW_FLAG_EN undefined: ovf port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//   Shared package nsa_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIBBLE_W=4.
//   One sub-module: cla4_slice. It is combinational 4-bit generate/propagate lookahead.
//     Ports: a[3:0], b[3:0], ci, s[3:0], co, c3.
//     It is instantiated once and shared across all nibble cycles.
//   Top level holds the FSM, operand regs, idx counter, carry reg and result regs.
// TESTING (WIDTH=16 unless stated)
//   1. a=0x0001, b=0x000F, cin=0 -> out_valid 4 cycles after accept; sum=0x0010, cout=0.
//   2. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples through all 4 nibble cycles).
//   3. a=0xFFFF, b=0xFFFF, cin=0 -> sum=0xFFFE, cout=1. Hold out_ready=0 for 5 cycles:
//      out_valid stays 1, sum stable, in_ready=0.
//   4. in_valid held high with new operands during RUN -> ignored.
//      Second op accepted only after out_ready handshake; back-to-back results are both correct.
//   5. Assert rst_n=0 at RUN idx=2 -> out_valid=0 and sum=0 immediately.
//      After release: in_ready=1; the next op 0x1234+0x4321 gives 0x5555.
//   6. OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0xFFFF+0x0001 -> ovf=0, cout=1.
//      WIDTH=4 build: 0x9+0x8 -> sum=0x1, cout=1 after 1 cycle.

Source files
------------

// File: rtl/nsa_pkg.sv
// nsa_pkg: shared FSM encoding and slice width for nibble_serial_adder.
package nsa_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit generate/propagate carry-lookahead adder.
// With OVERFLOW_FLAG_EN it also exports the carry into bit 3 (c3).
module cla4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                c3
`endif
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;
  assign w_g = a & b;
  assign w_p = a ^ b;
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                | (&w_p & ci);
  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];
`ifdef OVERFLOW_FLAG_EN
  assign c3 = w_c[3];
`endif
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add sequenced one nibble per cycle through a shared CLA slice.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [IW-1:0] r_idx;
  logic r_carry, r_cout, w_co, w_last;
  logic [NIBBLE_W-1:0] w_s;
`ifdef OVERFLOW_FLAG_EN
  logic r_ovf, w_c3;
  assign ovf = r_ovf;
`endif

  assign w_last    = r_idx == LAST;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign sum       = r_sum;
  assign cout      = r_cout;

  cla4_slice u_slice (
    .a  (r_a[r_idx*NIBBLE_W +: NIBBLE_W]),
    .b  (r_b[r_idx*NIBBLE_W +: NIBBLE_W]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
`ifdef OVERFLOW_FLAG_EN
    ,
    .c3 (w_c3)
`endif
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (in_valid ? RUN : IDLE)
           : r_state == RUN  ? (w_last ? DONE : RUN)
           : r_state == DONE ? (out_ready ? IDLE : DONE)
           : IDLE;
  end

  // idx returns to 0 on the last nibble so it never leaves 0..NIBBLES-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
      r_carry <= w_co;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_co;
`ifdef OVERFLOW_FLAG_EN
        r_ovf  <= w_c3 ^ w_co;
`endif
      end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors with literal expectations plus a per-cycle
// arithmetic reference model for the WIDTH=16 instance; a WIDTH=4 instance is also exercised.
module tb_nibble_serial_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout;
  logic [W-1:0] sum;
  logic v4 = 1'b0, c4 = 1'b0, r4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic rdy4, vld4, cout4;
  logic [3:0] sum4;
`ifdef OVERFLOW_FLAG_EN
  logic ovf, ovf4;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
    .a(a4), .b(b4), .cin(c4), .out_valid(vld4), .out_ready(r4),
    .sum(sum4), .cout(cout4)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf4)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W-1:0] s;
    s = x + y + W'(c);
    return x[W-1] == y[W-1] && s[W-1] != x[W-1];
  endfunction

  // Reference: one op in flight; result a+b+cin appears N edges after acceptance
  logic m_busy = 1'b0, m_vld = 1'b0, m_ovf = 1'b0;
  logic [W:0] m_res = '0;
  int cyc = 0, acc = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
      cyc    <= 0;
      acc    <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy && m_vld && out_ready) begin
        m_busy <= 1'b0;
        m_vld  <= 1'b0;
      end else if (!m_busy && in_valid) begin
        m_busy <= 1'b1;
        acc    <= cyc + 1;
        m_res  <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        m_ovf  <= sovf(a, b, cin);
      end else if (m_busy && cyc + 1 - acc >= N) m_vld <= 1'b1;
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("model out_valid", 32'(out_valid), 32'(m_vld));
      chk("model in_ready", 32'(in_ready), 32'(!m_busy));
      if (m_vld) begin
        chk("model sum", 32'(sum), 32'(m_res[W-1:0]));
        chk("model cout", 32'(cout), 32'(m_res[W]));
`ifdef OVERFLOW_FLAG_EN
        chk("model ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'b1;
  endtask

  task automatic wait_done(input logic [W-1:0] es, input logic ec, input logic eo);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(N));
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
`ifdef OVERFLOW_FLAG_EN
    chk("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x flag");
`endif
  endtask

  task automatic release_out(input int hold, input logic [W-1:0] es);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      chk("hold sum", 32'(sum), 32'(es));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid after handshake", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    chk("reset in_ready", 32'(in_ready), 32'd1);

    start(16'h0001, 16'h000F, 1'b0);
    wait_done(16'h0010, 1'b0, 1'b0);
    release_out(0, 16'h0010);

    start(16'hFFFF, 16'h0000, 1'b1);
    wait_done(16'h0000, 1'b1, 1'b0);
    release_out(0, 16'h0000);

    start(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done(16'hFFFE, 1'b1, 1'b0);
    release_out(5, 16'hFFFE);

    // in_valid stays high while busy: ignored until the result handshake
    start(16'h0F0F, 16'h00F1, 1'b0);
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    wait_done(16'h1000, 1'b0, 1'b0);
    release_out(0, 16'h1000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(16'h3333, 1'b0, 1'b0);
    release_out(0, 16'h3333);

    // abort at idx=2 with a partially written sum
    start(16'hAAAA, 16'h1111, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post-abort in_ready", 32'(in_ready), 32'd1);
    start(16'h1234, 16'h4321, 1'b0);
    wait_done(16'h5555, 1'b0, 1'b0);
    release_out(0, 16'h5555);

`ifdef OVERFLOW_FLAG_EN
    start(16'h7FFF, 16'h0001, 1'b0);
    wait_done(16'h8000, 1'b0, 1'b1);
    release_out(0, 16'h8000);
    start(16'hFFFF, 16'h0001, 1'b0);
    wait_done(16'h0000, 1'b1, 1'b0);
    release_out(0, 16'h0000);
`endif

    a4 = 4'h9; b4 = 4'h8; c4 = 1'b0; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    lat4 = 0;
    while (!vld4 && lat4 < 20) begin
      @(posedge clk); #1;
      lat4++;
    end
    chk("w4 latency", 32'(lat4), 32'd1);
    chk("w4 sum", 32'(sum4), 32'h1);
    chk("w4 cout", 32'(cout4), 32'd1);
`ifdef OVERFLOW_FLAG_EN
    chk("w4 ovf", 32'(ovf4), 32'd1);
`endif
    r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
    chk("w4 out_valid after handshake", 32'(vld4), 32'd0);
    chk("w4 in_ready", 32'(rdy4), 32'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
